// File: rtl/mul_arb_ctrl.sv
// rtl/mul_arb_ctrl.sv - round-robin arbiter sharing one 8x8 unsigned multiplier
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/a/b       per-requester operation request and operands (8 bits each)
//   req_ready           one-hot grant, combinational, only in IDLE
//   rsp_valid/id/data   result handshake: owner index and 16-bit product
//   rsp_ready           consumer accepts the result
//   busy                high while an operation is in flight
//   op_count            completed results, wraps modulo 2**16

module mul8x8_array (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // Shift-and-add over the rows of partial products.
    always_comb begin
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + (16'(a) << i);
            end
        end
    end
endmodule

module mul_arb_ctrl #(
    parameter int N_REQ = 4,
    parameter int IDW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_data,
    input  logic               rsp_ready,
    output logic               busy,
    output logic [15:0]        op_count
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic           grant_vld;
    logic [IDW:0]   cand;
    logic           accept;
    logic [7:0]     sel_a, sel_b;
    logic [7:0]     op_a, op_b;
    logic [IDW-1:0] op_id;
    logic [15:0]    product;

    // Round-robin search: scan distances from rr_ptr downward so the
    // nearest pending requester (smallest distance) is the last one written.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (req_valid[j] && cand == (IDW+1)'(j)) begin
                    grant_vld = 1'b1;
                    grant_idx = IDW'(j);
                end
            end
        end
    end

    assign accept = grant_vld && (state == IDLE) && !rst;
    assign busy   = (state != IDLE);

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_idx == IDW'(j)) begin
                req_ready[j] = accept;
                sel_a        = req_a[8*j +: 8];
                sel_b        = req_b[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mul8x8_array u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_id  <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
            end
            if (state == MUL) begin
                rsp_data  <= product;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mul_arb_ctrl.sv
// tb/tb_mul_arb_ctrl.sv - randomized bench for mul_arb_ctrl against a transaction model

module tb_mul_arb_ctrl;
    localparam int N   = 4;
    localparam int IDW = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [15:0]    rsp_data;
    logic           rsp_ready;
    logic           busy;
    logic [15:0]    op_count;

    mul_arb_ctrl #(.N_REQ(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester side: pending flags and operands offered by each requester.
    logic [N-1:0] pend;
    logic [7:0]   pa [N];
    logic [7:0]   pb [N];
    logic         rsp_rdy;

    // Transaction model: in-flight phase (-1 none, 0 computing, 1 result shown).
    int          ptr;
    int          age;
    int          exp_id;
    logic [15:0] exp_data;
    logic [15:0] last_data;
    logic [15:0] cnt;
    int          grants[$];
    int          grant_cyc[$];
    int          cyc;

    task automatic cycle();
        int g;
        int idx;
        logic [N-1:0] exp_rdy;
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = pa[i];
            req_b[8*i +: 8] = pb[i];
        end
        rsp_ready = rsp_rdy;
        #1;
        g = -1;
        if (age < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (pend[idx] && g < 0) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(age >= 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(age == 1));
        if (age == 1) chk("rsp_id", 32'(rsp_id), 32'(exp_id));
        chk("rsp_data", 32'(rsp_data), 32'(last_data));
        chk("op_count", 32'(op_count), 32'(cnt));
        if (g >= 0) begin
            exp_id   = g;
            exp_data = 16'(pa[g]) * 16'(pb[g]);
            pend[g]  = 1'b0;
            ptr      = (g + 1) % N;
            age      = 0;
            grants.push_back(g);
            grant_cyc.push_back(cyc);
        end else if (age == 0) begin
            age       = 1;
            last_data = exp_data;
        end else if (age == 1 && rsp_rdy) begin
            age = -1;
            cnt = cnt + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_op_count", 32'(op_count), 0);
        ptr       = 0;
        age       = -1;
        cnt       = '0;
        last_data = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while (!(pend == '0 && age < 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        if (!(pend == '0 && age < 0)) chk("idle_timeout", 0, 1);
    endtask

    task automatic single_op(input int r, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] prod, input string tag);
        pa[r]   = a;
        pb[r]   = b;
        pend[r] = 1'b1;
        run_until_idle(10);
        chk(tag, 32'(rsp_data), 32'(prod));
    endtask

    initial begin
        rst       = 1'b1;
        pend      = '0;
        rsp_rdy   = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        ptr = 0; age = -1; cnt = '0; last_data = '0; exp_data = '0; exp_id = 0; cyc = 0;
        @(negedge clk);
        do_reset();

        // Single operation with maximum operands.
        single_op(0, 8'd255, 8'd255, 16'hFE01, "single_data");
        chk("single_cnt", 32'(op_count), 1);
        chk("single_grants", 32'(grants.size()), 1);

        // Round robin with all requesters held valid.
        do_reset();
        grants.delete();
        grant_cyc.delete();
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < N; i++) begin
                pa[i] = 8'(i + 1);
                pb[i] = 8'd3;
            end
            pend = '1;
            cycle();
        end
        pend = '0;
        run_until_idle(10);
        chk("rr_count", 32'(grants.size()), 5);
        if (grants.size() >= 5) begin
            chk("rr_g0", 32'(grants[0]), 0);
            chk("rr_g1", 32'(grants[1]), 1);
            chk("rr_g2", 32'(grants[2]), 2);
            chk("rr_g3", 32'(grants[3]), 3);
            chk("rr_g4", 32'(grants[4]), 0);
            for (int i = 1; i < 5; i++)
                chk("rr_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 3);
        end

        // Backpressure: result held while the consumer stalls.
        pa[2] = 8'd7; pb[2] = 8'd9; pend = 4'b0100; rsp_rdy = 1'b0;
        cycle();
        pend = 4'b1011;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_busy", 32'(busy), 1);
        chk("bp_data", 32'(rsp_data), 32'd63);
        rsp_rdy = 1'b1;
        cycle();
        chk("bp_done_cnt", 32'(op_count), 32'(cnt));
        run_until_idle(20);

        // Edge operands.
        single_op(1, 8'd0, 8'd200, 16'h0000, "edge_zero");
        single_op(1, 8'd1, 8'hAB, 16'h00AB, "edge_one");
        single_op(1, 8'h80, 8'h02, 16'h0100, "edge_shift");

        // Reset while an operation is in flight.
        do_reset();
        pa[2] = 8'd5; pb[2] = 8'd5; pend = 4'b0100;
        cycle();
        do_reset();
        pend = 4'b0110;
        grants.delete();
        cycle();
        chk("rstmid_first", 32'(grants[0]), 1);
        run_until_idle(20);

        // Randomized traffic with occasional asynchronous reset.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pa[i] = 8'($urandom);
                    pb[i] = 8'($urandom);
                    if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
                end
            end
            rsp_rdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end
        rsp_rdy = 1'b1;
        pend    = '0;
        run_until_idle(20);

        // Counter wrap: preload near the top, then complete three operations.
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        cnt = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pa[3] = 8'($urandom); pb[3] = 8'($urandom); pend[3] = 1'b1;
            run_until_idle(10);
        end
        chk("wrap", 32'(op_count), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mul_arb_ctrl.md
MUL_ARB_CTRL -- requirements
Module: mul_arb_ctrl

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 8x8 unsigned multiplier; legal range 2..8.
REQ-002 Parameter IDW, default 3, width of the requester index; SHALL satisfy 2**IDW >= N_REQ.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester operation request; bit i belongs to requester i.
REQ-006 req_a  input  8*N_REQ  multiplicand; bits [8i+7:8i] belong to requester i.
REQ-007 req_b  input  8*N_REQ  multiplier; bits [8i+7:8i] belong to requester i.
REQ-008 req_ready  output  N_REQ  one-hot or zero accept strobe; bit i is the grant to requester i.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  IDW  index of the requester that owns the result.
REQ-011 rsp_data  output  16  unsigned product a*b.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 op_count  output  16  number of completed results (rsp_valid & rsp_ready), wraps modulo 2**16.

Function
REQ-015 FSM states are IDLE, MUL and HOLD; no other states are reachable.
REQ-016 In IDLE, the grant goes to the first requester with req_valid=1, searching upward from rr_ptr with wrap at N_REQ-1 -> 0; req_ready is one-hot on that requester, combinational from req_valid and rr_ptr.
REQ-017 req_ready is all-zero in MUL and HOLD, and in IDLE when req_valid is all-zero.
REQ-018 Accept is req_valid[i] & req_ready[i]; on accept, operands of requester i and index i are registered, rr_ptr <= (i+1) mod N_REQ, and state -> MUL.
REQ-019 In MUL, rsp_data <= op_a*op_b (full 16-bit, no truncation), rsp_id <= captured index, rsp_valid <= 1, and state -> HOLD; latency from accept edge to rsp_valid=1 is 2 clock edges.
REQ-020 In HOLD, rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1; on rsp_valid & rsp_ready, rsp_valid <= 0, op_count increments, and state -> IDLE.
REQ-021 No new request is accepted in the same cycle a result is consumed; minimum issue interval is 3 cycles.
REQ-022 rr_ptr changes only on accept; a requester that is not granted keeps its request pending with no loss.
REQ-023 A requester holds req_valid, req_a and req_b stable until its req_ready; req_valid SHALL NOT depend on req_ready.
REQ-024 A deasserted req_valid in IDLE has no effect on state; changes to req_a/req_b after accept do not alter the result in flight.
REQ-025 rsp_data keeps its last value while rsp_valid=0.
REQ-026 op_count wraps 16'hFFFF -> 16'h0000 without side effects.
REQ-027 The product is computed by one instance of the team's 8x8 array multiplier fed from the operand registers; there is exactly one multiplier per instance of this block.

Reset
REQ-028 While rst=1, independent of clk: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, busy=0, and req_ready=0.
REQ-029 Assertion of rst in MUL or HOLD discards the operation in flight with no response; after release, arbitration restarts at requester 0.
REQ-030 The first accept can occur on the first rising edge after rst deasserts.

Verification
REQ-031 Single op: rst pulse; req_valid=0001, a0=8'd255, b0=8'd255, rsp_ready=1 -> req_ready=0001 for one cycle, rsp_valid 2 edges later with rsp_id=0, rsp_data=16'hFE01, op_count=1.
REQ-032 Round-robin: req_valid=1111 held, each requester i with a=i+1, b=3, rsp_ready=1 -> grants in order 0,1,2,3,0; results 3,6,9,12; spacing of 3 cycles.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_id/rsp_data stable, req_ready=0, busy=1; rsp_ready=1 -> one completion, IDLE next cycle.
REQ-034 Reset mid-op: accept from requester 2, assert rst in MUL -> no rsp_valid, op_count=0; with req_valid=0110 after release, requester 1 is granted first.
REQ-035 Edge operands: a=0,b=200 -> 0; a=1,b=8'hAB -> 16'h00AB; a=8'h80,b=8'h02 -> 16'h0100.
REQ-036 Wrap: force 65537 completions (or preload via test mode) -> op_count reads 16'h0001.
